// File: rtl/exe_muldiv_pkg.sv
// Shared EXE-stage definitions for the iterative multiply/divide unit.
// Holds the funct decode constants, FSM encoding, step count and a sign helper.
package exe_muldiv_pkg;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MTHI     = 6'h11;
   localparam logic [5:0] FN_MTLO     = 6'h13;
   localparam logic [5:0] FN_MULT     = 6'h18;
   localparam logic [5:0] FN_MULTU    = 6'h19;
   localparam logic [5:0] FN_DIV      = 6'h1A;
   localparam logic [5:0] FN_DIVU     = 6'h1B;

   localparam int                MD_STEPS = 32;
   localparam int                CNT_W    = $clog2(MD_STEPS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
      return en ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Purely combinational; the caller registers {hi,lo} every cycle.
module muldiv_step
   import exe_muldiv_pkg::*;
(
   input  logic        is_div,
   input  logic [31:0] opnd,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic        ge;

   always_comb begin
      sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : 33'd0);
      shifted = {hi_in, lo_in[31]};
      ge      = (shifted >= {1'b0, opnd});
      if (is_div) begin
         // partial remainder is always below the divisor, so 32 bits suffice
         hi_out = ge ? (shifted[31:0] - opnd) : shifted[31:0];
         lo_out = {lo_in[30:0], ge};
      end else begin
         hi_out = sum[32:1];
         lo_out = {sum[0], lo_in[31:1]};
      end
   end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO; 34-cycle stall per mul/div.
// stall holds upstream during issue, RUN and FIX; flush aborts without touching HI/LO.
module exe_muldiv
   import exe_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue,
   input  logic        flush,
   input  logic [31:0] instruction,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_t        state, state_nxt;
   logic [5:0]       opc, fn;
   logic             is_special, is_mul, is_div, is_muldiv, is_sgn, is_mthi, is_mtlo;
   logic             start, step_en, fix_wr, mt_wr, stall_c;
   logic [CNT_W-1:0] cnt;
   logic             md_div, neg_q, neg_r, b_zero;
   logic [31:0]      opnd, p_hi, p_lo, step_hi, step_lo;
   logic [31:0]      a_mag, b_mag, fix_hi, fix_lo;
   logic [63:0]      prod_fix;
   logic             unused_instr;

   assign opc          = instruction[31:26];
   assign fn           = instruction[5:0];
   assign unused_instr = ^instruction[25:6];
   assign is_special   = (opc == OPC_SPECIAL);
   assign is_mul       = is_special && (fn == FN_MULT || fn == FN_MULTU);
   assign is_div       = is_special && (fn == FN_DIV  || fn == FN_DIVU);
   assign is_muldiv    = is_mul || is_div;
   assign is_sgn       = (fn == FN_MULT || fn == FN_DIV);
   assign is_mthi      = is_special && (fn == FN_MTHI);
   assign is_mtlo      = is_special && (fn == FN_MTLO);

   assign a_mag = cond_neg32(A, is_sgn && A[31]);
   assign b_mag = cond_neg32(B, is_sgn && B[31]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      done      = 1'b0;
      start     = 1'b0;
      step_en   = 1'b0;
      fix_wr    = 1'b0;
      mt_wr     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (issue && !flush) begin
               if (is_muldiv) begin
                  start     = 1'b1;
                  stall_c   = 1'b1;
                  state_nxt = ST_RUN;
               end else if (is_mthi || is_mtlo) begin
                  mt_wr = 1'b1;
               end
            end
         end
         ST_RUN: begin
            stall_c = 1'b1;
            if (flush) begin
               state_nxt = ST_IDLE;
            end else begin
               step_en = 1'b1;
               if (cnt == CNT_LAST) state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            stall_c = 1'b1;
            if (flush) begin
               state_nxt = ST_IDLE;
            end else begin
               fix_wr    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // an issue held high during reset must not leak a stall
   assign stall = stall_c && rst_n;

   muldiv_step u_step (
      .is_div (md_div),
      .opnd   (opnd),
      .hi_in  (p_hi),
      .lo_in  (p_lo),
      .hi_out (step_hi),
      .lo_out (step_lo)
   );

   // divide by zero: the remainder path already yields A once sign-restored
   always_comb begin
      prod_fix = {p_hi, p_lo};
      if (neg_q) prod_fix = ~prod_fix + 64'd1;
      if (md_div) begin
         fix_hi = cond_neg32(p_hi, neg_r);
         fix_lo = b_zero ? 32'hFFFF_FFFF : cond_neg32(p_lo, neg_q);
      end else begin
         fix_hi = prod_fix[63:32];
         fix_lo = prod_fix[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi     <= 32'd0;
         lo     <= 32'd0;
         cnt    <= '0;
         opnd   <= 32'd0;
         p_hi   <= 32'd0;
         p_lo   <= 32'd0;
         md_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         if (start) begin
            md_div <= is_div;
            neg_q  <= (is_sgn && A[31]) ^ (is_sgn && B[31]);
            neg_r  <= is_sgn && A[31];
            b_zero <= is_div && (B == 32'd0);
            cnt    <= '0;
            p_hi   <= 32'd0;
            p_lo   <= is_div ? a_mag : b_mag;
            opnd   <= is_div ? b_mag : a_mag;
         end
         if (step_en) begin
            p_hi <= step_hi;
            p_lo <= step_lo;
            cnt  <= cnt + CNT_W'(1);
         end
         if (fix_wr) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end
         if (mt_wr && is_mthi) hi <= A;
         if (mt_wr && is_mtlo) lo <= A;
      end
   end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed checks for exe_muldiv: arithmetic results, 34-cycle stall timing,
// flush/reset aborts, MTHI/MTLO writes and ignored issues.
module tb_exe_muldiv;
   import exe_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] instruction = 32'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        stall, done;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   exe_muldiv dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue       (issue),
      .flush       (flush),
      .instruction (instruction),
      .A           (A),
      .B           (B),
      .stall       (stall),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [5:0] f);
      return {6'h00, 20'h0, f};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit issue_in_done);
      int stalls;
      int n;
      bit seen;
      stalls = 0;
      n      = 0;
      seen   = 1'b0;
      instruction = rtype(f);
      A     = a;
      B     = b;
      flush = 1'b0;
      issue = 1'b1;
      #1;
      while (!seen && n < 100) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (stall) stalls++;
            step();
            issue = 1'b0;
            #1;
            n++;
         end
      end
      check({tag, " done seen"}, 64'(seen), 64'd1);
      check({tag, " stall cycles"}, 64'(stalls), 64'd34);
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      if (issue_in_done) begin
         instruction = rtype(FN_MULTU);
         issue = 1'b1;
         #1;
         check({tag, " stall in done"}, 64'(stall), 64'd0);
      end
      step();
      issue = 1'b0;
      #1;
      check({tag, " done width"}, 64'(done), 64'd0);
      check({tag, " stall after done"}, 64'(stall), 64'd0);
   endtask

   initial begin
      int dcnt;
      int scnt;

      // reset with an issue held high
      instruction = rtype(FN_MULT);
      issue = 1'b1;
      A = 32'd3;
      B = 32'd4;
      #12;
      check("reset stall", 64'(stall), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      issue = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      do_op("mult -1*2",   FN_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      do_op("multu ff*2",  FN_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b1);
      do_op("div -7/2",    FN_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      do_op("divu 7/0",    FN_DIVU,  32'd7,        32'd0, 32'h00000007, 32'hFFFFFFFF, 1'b0);
      do_op("div -7/0",    FN_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

      // flush on the 10th RUN cycle
      instruction = rtype(FN_MULT);
      A = 32'd3;
      B = 32'd5;
      issue = 1'b1;
      #1;
      check("flush issue stall", 64'(stall), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         issue = 1'b0;
         #1;
      end
      flush = 1'b1;
      #1;
      check("flush run stall", 64'(stall), 64'd1);
      step();
      flush = 1'b0;
      #1;
      check("flush stall drop", 64'(stall), 64'd0);
      check("flush hi kept", 64'(hi), 64'hFFFFFFF9);
      check("flush lo kept", 64'(lo), 64'hFFFFFFFF);
      dcnt = 0;
      scnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dcnt++;
         if (stall) scnt++;
         step();
      end
      check("flush no done", 64'(dcnt), 64'd0);
      check("flush no stall", 64'(scnt), 64'd0);

      // issue and flush together: nothing starts, nothing written
      instruction = rtype(FN_MULT);
      issue = 1'b1;
      flush = 1'b1;
      #1;
      check("issue+flush stall", 64'(stall), 64'd0);
      step();
      instruction = rtype(FN_MTHI);
      A = 32'hDEAD;
      #1;
      check("issue+flush no run", 64'(stall), 64'd0);
      step();
      issue = 1'b0;
      flush = 1'b0;
      #1;
      check("mthi flushed hi", 64'(hi), 64'hFFFFFFF9);

      // MTHI / MTLO
      instruction = rtype(FN_MTHI);
      A = 32'h1234;
      issue = 1'b1;
      #1;
      check("mthi stall", 64'(stall), 64'd0);
      step();
      issue = 1'b0;
      #1;
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi lo kept", 64'(lo), 64'hFFFFFFFF);
      check("mthi done", 64'(done), 64'd0);
      instruction = rtype(FN_MTLO);
      A = 32'h5678;
      issue = 1'b1;
      #1;
      check("mtlo stall", 64'(stall), 64'd0);
      step();
      issue = 1'b0;
      #1;
      check("mtlo lo", 64'(lo), 64'h5678);
      check("mtlo hi kept", 64'(hi), 64'h1234);

      // unrelated instruction is ignored
      instruction = rtype(6'h20);
      A = 32'hAAAA;
      issue = 1'b1;
      #1;
      check("other stall", 64'(stall), 64'd0);
      step();
      issue = 1'b0;
      #1;
      check("other hi kept", 64'(hi), 64'h1234);
      check("other lo kept", 64'(lo), 64'h5678);

      do_op("div 100/7",   FN_DIV,   32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      do_op("div min/-1",  FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      do_op("mult min^2",  FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      do_op("div 7/-2",    FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      do_op("divu ff/16",  FN_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0);

      // reset on the 5th RUN cycle
      instruction = rtype(FN_MULTU);
      A = 32'd5;
      B = 32'd6;
      issue = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         step();
         issue = 1'b0;
         #1;
      end
      check("pre-reset stall", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrun reset hi", 64'(hi), 64'd0);
      check("midrun reset lo", 64'(lo), 64'd0);
      check("midrun reset stall", 64'(stall), 64'd0);
      check("midrun reset done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post-reset idle", 64'(stall), 64'd0);
      do_op("multu post-reset", FN_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 issue  in  1  high for exactly the first cycle a new instruction sits in the EXE stage.
REQ-004 flush  in  1  kill in-flight EXE operation (branch redirect / exception).
REQ-005 instruction  in  32  EXE-stage instruction word from the ID/EXE buffer.
REQ-006 A  in  32  rs operand (dividend / multiplicand); B  in  32  rt operand (divisor / multiplier).
REQ-007 stall  out  1  freeze request; while high, the ID/EXE buffer and upstream stages hold.
REQ-008 done  out  1  one-cycle pulse when a new HI/LO result becomes architecturally visible.
REQ-009 hi  out  32  HI register; lo  out  32  LO register; both read directly by MFHI/MFLO.

Function
REQ-010 Decode SHALL treat opcode 6'h00 with funct 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU, 6'h11 MTHI, 6'h13 MTLO; all other words are ignored.
REQ-011 States SHALL be IDLE, RUN, FIX, DONE.
REQ-012 IDLE: issue with MULT/MULTU/DIV/DIVU and no flush -> RUN, latch operand magnitudes and sign flags, cycle counter = 0.
REQ-013 IDLE: issue with MTHI/MTLO and no flush -> write A into hi/lo at that edge; no stall; no done pulse; state stays IDLE.
REQ-014 RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide); exit to FIX after exactly 32 steps.
REQ-015 FIX: apply two's-complement sign correction (signed ops only), write hi/lo at the edge, -> DONE.
REQ-016 DONE: done=1, stall=0 for one cycle; -> IDLE unconditionally; an issue seen in DONE is ignored.
REQ-017 stall SHALL be combinational = (IDLE & issue & is_muldiv & ~flush) | RUN | FIX, so a multiply/divide holds the pipeline for 34 cycles: the issue cycle, 32 RUN cycles and 1 FIX cycle.
REQ-018 Multiply result: {hi,lo} = full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-019 Divide result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-020 Divisor zero: same latency; hi = A, lo = 32'hFFFFFFFF, for both DIV and DIVU.
REQ-021 DIV 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-022 Flush in RUN or FIX: -> IDLE next edge; hi/lo unchanged; no done pulse; stall low from the next cycle.
REQ-023 Flush with issue in the same cycle: flush wins; nothing starts; no register write.
REQ-024 issue outside IDLE is ignored.
REQ-025 hi/lo SHALL change only in the FIX-edge or MTHI/MTLO-edge cases.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE and clear hi, lo, counter and operand latches to 0.
REQ-027 During reset: stall=0, done=0.
REQ-028 Reset in mid-RUN discards the operation; the first cycle after release behaves as IDLE.

Structure
REQ-029 Shared pipeline package SHALL hold the funct constants, the state encoding and the step count (32).
REQ-030 One sub-module, muldiv_step, SHALL implement a single combinational radix-2 step (add or subtract, shift); exe_muldiv owns the FSM, counter, sign handling and HI/LO.
REQ-031 Total RTL 120-400 lines; no multi-cycle combinational paths; no `*` or `/` operators.

Verification
REQ-032 MULT A=32'hFFFFFFFF, B=2 -> after 34 stall cycles, done pulse, hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
REQ-033 MULTU with the same operands -> hi=32'h00000001, lo=32'hFFFFFFFE, same timing.
REQ-034 DIV A=-7 (32'hFFFFFFF9), B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU A=7, B=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-035 MULT, then flush on the 10th RUN cycle -> stall=0 next cycle, hi/lo keep prior values, no done pulse.
REQ-036 MTHI A=32'h1234 -> hi=32'h1234 after one edge, stall never high; then DIV issued in the cycle after DONE starts normally.
REQ-037 rst_n low on the 5th RUN cycle -> hi=lo=0, stall=0 immediately; a MULTU issued after release completes correctly.
